ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arbiter_rr_arb2.sv | 33 +++
 rtl/ram_arbiter.sv | 92 +++++++++
 tb/tb_ram_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared defaults, client indices and the saturating counter helper for ram_arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 4;
    localparam int CNT_W      = 8;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req == 2'b11)
                gnt = (ptr == CLIENT1) ? 2'b10 : 2'b01;
            else
                gnt = req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= CLIENT0;
        else if (gnt[0])
            ptr <= CLIENT1;
        else if (gnt[1])
            ptr <= CLIENT0;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-client arbiter onto a 1R1W RAM with independent round-robin per port.
// Build option RAM_ARB_RAW_BYPASS_EN: same-cycle same-address read returns the write data.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_gnt,
    output logic              c0_rvalid,
    output logic [DATA_W-1:0] c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_gnt,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              read_en,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] read_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [1:0]        wreq, rreq, wgnt, rgnt;
    logic [1:0]        n_conf;
    logic              rd_pend, rd_owner;
    logic [DATA_W-1:0] rd_src;

    assign wreq = {c1_req & c1_we, c0_req & c0_we};
    assign rreq = {c1_req & ~c1_we, c0_req & ~c0_we};

    rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req(wreq), .gnt(wgnt));
    rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req(rreq), .gnt(rgnt));

    assign c0_gnt = wgnt[0] | rgnt[0];
    assign c1_gnt = wgnt[1] | rgnt[1];

    assign write_en   = |wgnt;
    assign write_addr = wgnt[1] ? c1_addr  : c0_addr;
    assign write_data = wgnt[1] ? c1_wdata : c0_wdata;
    assign read_en    = |rgnt;
    assign read_addr  = rgnt[1] ? c1_addr  : c0_addr;

    assign n_conf = {1'b0, &wreq} + {1'b0, &rreq};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend      <= 1'b0;
            rd_owner     <= CLIENT0;
            conflict_cnt <= '0;
        end else begin
            rd_pend      <= read_en;
            rd_owner     <= rgnt[1] ? CLIENT1 : CLIENT0;
            conflict_cnt <= sat_add(conflict_cnt, n_conf);
        end
    end

`ifdef RAM_ARB_RAW_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_hit  <= 1'b0;
            byp_data <= '0;
        end else begin
            byp_hit  <= read_en & write_en & (read_addr == write_addr);
            byp_data <= write_data;
        end
    end

    assign rd_src = byp_hit ? byp_data : read_data;
`else
    assign rd_src = read_data;
`endif

    assign c0_rvalid = rd_pend & (rd_owner == CLIENT0);
    assign c1_rvalid = rd_pend & (rd_owner == CLIENT1);
    assign c0_rdata  = c0_rvalid ? rd_src : '0;
    assign c1_rdata  = c1_rvalid ? rd_src : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter against a transaction-level model; honours RAM_ARB_RAW_BYPASS_EN.
module tb_ram_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;
`ifdef RAM_ARB_RAW_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk, rst;
    logic              c0_req, c0_we, c1_req, c1_we;
    logic [ADDR_W-1:0] c0_addr, c1_addr;
    logic [DATA_W-1:0] c0_wdata, c1_wdata;
    logic              c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
    logic [DATA_W-1:0] c0_rdata, c1_rdata;
    logic              write_en, read_en;
    logic [ADDR_W-1:0] write_addr, read_addr;
    logic [DATA_W-1:0] write_data, read_data;
    logic [7:0]        conflict_cnt;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .read_en(read_en), .read_addr(read_addr), .read_data(read_data),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM environment: registered read, read-before-write.
    logic [DATA_W-1:0] mem [256];
    always @(posedge clk) begin
        if (read_en)  read_data <= mem[read_addr];
        if (write_en) mem[write_addr] <= write_data;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: priority holder per port, expected read returns, saturating conflict total.
    int ptr_w, ptr_r, cnt;
    int ref_mem [256];
    bit exp_rv [2];
    int exp_rd [2];
    int last_w, last_r;
    int seen_g0;

    function automatic int pick(input bit r0, input bit r1, input int prio);
        if (r0 && r1) return prio;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic int cl_addr(input int c);
        return c == 1 ? int'(c1_addr) : int'(c0_addr);
    endfunction

    function automatic int cl_data(input int c);
        return c == 1 ? int'(c1_wdata) : int'(c0_wdata);
    endfunction

    task automatic model_reset();
        ptr_w = 0; ptr_r = 0; cnt = 0;
        exp_rv[0] = 0; exp_rv[1] = 0;
        exp_rd[0] = 0; exp_rd[1] = 0;
        last_w = -1; last_r = -1;
    endtask

    task automatic set_client(input int c, input bit req, input bit we, input int addr, input int data);
        if (c == 0) begin
            c0_req = req; c0_we = we; c0_addr = 8'(addr); c0_wdata = 4'(data);
        end else begin
            c1_req = req; c1_we = we; c1_addr = 8'(addr); c1_wdata = 4'(data);
        end
    endtask

    // One clock: check combinational outputs and registered returns mid-cycle, then advance the model.
    task automatic cycle();
        int wwin, rwin, ra, wa;
        @(negedge clk);
        wwin = pick(c0_req && c0_we, c1_req && c1_we, ptr_w);
        rwin = pick(c0_req && !c0_we, c1_req && !c1_we, ptr_r);
        seen_g0 = int'(c0_gnt);
        chk("c0_gnt", int'(c0_gnt), int'(wwin == 0 || rwin == 0));
        chk("c1_gnt", int'(c1_gnt), int'(wwin == 1 || rwin == 1));
        chk("write_en", int'(write_en), int'(wwin >= 0));
        chk("read_en", int'(read_en), int'(rwin >= 0));
        if (wwin >= 0) begin
            chk("write_addr", int'(write_addr), cl_addr(wwin));
            chk("write_data", int'(write_data), cl_data(wwin));
        end
        if (rwin >= 0) chk("read_addr", int'(read_addr), cl_addr(rwin));
        chk("c0_rvalid", int'(c0_rvalid), int'(exp_rv[0]));
        chk("c1_rvalid", int'(c1_rvalid), int'(exp_rv[1]));
        chk("c0_rdata", int'(c0_rdata), exp_rv[0] ? exp_rd[0] : 0);
        chk("c1_rdata", int'(c1_rdata), exp_rv[1] ? exp_rd[1] : 0);
        chk("conflict_cnt", int'(conflict_cnt), cnt);

        exp_rv[0] = 0; exp_rv[1] = 0;
        wa = (wwin >= 0) ? cl_addr(wwin) : -1;
        if (rwin >= 0) begin
            ra = cl_addr(rwin);
            exp_rv[rwin] = 1;
            exp_rd[rwin] = (BYPASS && wa == ra) ? cl_data(wwin) : ref_mem[ra];
        end
        if (wwin >= 0) begin
            ref_mem[wa] = cl_data(wwin);
            ptr_w = 1 - wwin;
        end
        if (rwin >= 0) ptr_r = 1 - rwin;
        if (c0_req && c0_we && c1_req && c1_we) cnt++;
        if (c0_req && !c0_we && c1_req && !c1_we) cnt++;
        if (cnt > 255) cnt = 255;
        last_w = wwin; last_r = rwin;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_client(input int c);
        bit req_now;
        req_now = (c == 1) ? c1_req : c0_req;
        if (req_now && last_w != c && last_r != c) return;
        set_client(c, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7), $urandom_range(0, 15));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = 0;
        end
        read_data = '0;
        rst = 1'b1;
        set_client(0, 1, 0, 1, 0);
        set_client(1, 1, 0, 2, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_c0_gnt", int'(c0_gnt), 0);
        chk("rst_c1_gnt", int'(c1_gnt), 0);
        chk("rst_read_en", int'(read_en), 0);
        chk("rst_rvalid", int'(c0_rvalid | c1_rvalid), 0);
        chk("rst_cnt", int'(conflict_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Both read every cycle: alternate c0,c1,c0,c1 and four conflicts.
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_order_c0", seen_g0, int'(i % 2 == 0));
        end
        chk("conf_after4", int'(conflict_cnt), 4);

        set_client(0, 0, 0, 0, 0);
        set_client(1, 0, 0, 0, 0);
        cycle();

        // Write then read back through the other client.
        set_client(0, 1, 1, 'h10, 'h5);
        cycle();
        set_client(0, 0, 0, 0, 0);
        set_client(1, 1, 0, 'h10, 0);
        cycle();
        set_client(1, 0, 0, 0, 0);
        chk("wr_rd_valid", int'(c1_rvalid), 1);
        chk("wr_rd_data", int'(c1_rdata), 'h5);
        chk("wr_rd_other", int'(c0_rvalid), 0);
        cycle();

        // Same-cycle collision at 0x20.
        set_client(0, 1, 1, 'h20, 'hA);
        set_client(1, 1, 0, 'h20, 0);
        cycle();
        set_client(0, 0, 0, 0, 0);
        set_client(1, 0, 0, 0, 0);
        chk("collide_data", int'(c1_rdata), BYPASS ? 'hA : 'h0);
        cycle();

        // Move read pointer to c1, then reset lands on a c1 read grant.
        set_client(0, 1, 0, 'h10, 0);
        cycle();
        set_client(0, 0, 0, 0, 0);
        set_client(1, 1, 0, 'h10, 0);
        @(negedge clk);
        chk("pre_rst_gnt", int'(c1_gnt), 1);
        #1 rst = 1'b1;
        #1;
        chk("in_rst_gnt", int'(c1_gnt), 0);
        @(posedge clk);
        #1;
        chk("rst_no_rvalid", int'(c1_rvalid), 0);
        chk("rst_cnt_clear", int'(conflict_cnt), 0);
        rst = 1'b0;
        model_reset();
        set_client(0, 1, 0, 3, 0);
        set_client(1, 1, 0, 4, 0);
        cycle();
        chk("rd_ptr_reset", seen_g0, 1);
        set_client(0, 1, 1, 5, 1);
        set_client(1, 1, 1, 6, 2);
        cycle();
        chk("wr_ptr_reset", seen_g0, 1);
        set_client(0, 0, 0, 0, 0);
        set_client(1, 0, 0, 0, 0);
        cycle();

        for (int i = 0; i < 200; i++) begin
            rand_client(0);
            rand_client(1);
            cycle();
        end

        set_client(0, 1, 0, 7, 0);
        set_client(1, 1, 0, 8, 0);
        for (int i = 0; i < 300; i++) cycle();
        chk("cnt_saturated", int'(conflict_cnt), 255);

        set_client(0, 0, 0, 0, 0);
        set_client(1, 0, 0, 0, 0);
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
